instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time and buffers
// responses in a small FIFO of {instr, pc} for the decoder.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg;
  logic [31:0]     req_addr_reg;
  logic [CW-1:0]   count_reg;
  logic [AW-1:0]   head_reg, tail_reg;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic            push, pop;

  assign pop       = if_valid & if_ready;
  assign imem_addr = pc_reg;

  // A redirect always wins: no request, no push, and a pending response is
  // either dropped on arrival (WAIT->DROP) or discarded right now.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    push       = 1'b0;
    case (state_reg)
      RUN: begin
        if (!rst && !redirect_valid && (count_reg < CW'(DEPTH))) begin
          imem_req   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          push       = ~redirect_valid;
          state_next = RUN;
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          state_next = DROP;
        end else if (imem_ack) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else if (redirect_valid) begin
      pc_reg    <= redirect_pc;
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      if (imem_req) begin
        pc_reg       <= pc_reg + 32'd4;
        req_addr_reg <= pc_reg;
      end
      if (push) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[tail_reg] <= imem_rdata;
      pc_mem[tail_reg]    <= req_addr_reg;
    end
  end

  assign if_valid  = (count_reg != '0);
  assign if_instr  = instr_mem[head_reg];
  assign if_pc     = pc_mem[head_reg];
  assign if_opcode = if_instr[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-stepped memory model plus one
// task per scenario, each comparing observed outputs against fixed values.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_ack, redirect_valid, if_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic [5:0]  if_opcode;

  int vectors = 0;
  int miscompares = 0;

  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  bit          force_ack = 1'b0;
  logic [31:0] force_data = 32'h0;

  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_instr;
  logic [5:0]  o_opcode;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2] ^ 6'h15, a[25:0] ^ 26'h2AA_AAAA};
  endfunction

  // One clock cycle: drive inputs at the falling edge, sample 1 ns later.
  task automatic step(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst = r;
    redirect_valid = redir;
    redirect_pc = rpc;
    if_ready = rdy;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    if (force_ack) begin
      imem_ack = 1'b1;
      imem_rdata = force_data;
      force_ack = 1'b0;
    end else if (mem_pending) begin
      if (mem_cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(mem_addr);
        mem_pending = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    #1;
    o_req = imem_req;
    o_addr = imem_addr;
    o_valid = if_valid;
    o_pc = if_pc;
    o_instr = if_instr;
    o_opcode = if_opcode;
    if (imem_req) begin
      mem_pending = 1'b1;
      mem_addr = imem_addr;
      mem_cnt = mem_lat - 1;
      $display("req  addr=%08h", imem_addr);
    end
    if (if_valid && if_ready) $display("pop  pc=%08h instr=%08h", if_pc, if_instr);
  endtask

  task automatic do_reset();
    mem_pending = 1'b0;
    force_ack = 1'b0;
    mem_lat = 1;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (o_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", o_req); end
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      miscompares++; $display("FAIL first_req: got req=%b addr=%08h expected req=1 addr=00000000", o_req, o_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (o_req !== (i % 2 == 0)) begin
        miscompares++; $display("FAIL stream_req[%0d]: got %b expected %b", i, o_req, (i % 2 == 0));
      end
      if (i % 2 == 0) begin
        vectors++;
        if (o_addr !== 32'(4 * (i / 2))) begin
          miscompares++; $display("FAIL stream_addr[%0d]: got %08h expected %08h", i, o_addr, 32'(4 * (i / 2)));
        end
      end
      vectors++;
      if (o_valid !== (i % 2 == 0 && i > 0)) begin
        miscompares++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, o_valid, (i % 2 == 0 && i > 0));
      end
      if (i % 2 == 0 && i > 0) begin
        w = mem_word(32'(4 * (i / 2 - 1)));
        vectors++;
        if (o_pc !== 32'(4 * (i / 2 - 1)) || o_instr !== w || o_opcode !== w[31:26]) begin
          miscompares++;
          $display("FAIL stream_head[%0d]: got pc=%08h instr=%08h op=%02h expected pc=%08h instr=%08h op=%02h",
                   i, o_pc, o_instr, o_opcode, 32'(4 * (i / 2 - 1)), w, w[31:26]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      if (o_req) nreq++;
      if (i >= 4) begin
        vectors++;
        if (o_req !== 1'b0) begin miscompares++; $display("FAIL bp_hold_req[%0d]: got %b expected 0", i, o_req); end
      end
    end
    vectors++;
    if (nreq !== 2) begin miscompares++; $display("FAIL bp_req_count: got %0d expected 2", nreq); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_req !== 1'b0) begin
      miscompares++; $display("FAIL bp_pop0: got valid=%b pc=%08h req=%b expected 1 00000000 0", o_valid, o_pc, o_req);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_req !== 1'b1 || o_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL bp_pop4: got valid=%b pc=%08h req=%b addr=%08h expected 1 00000004 1 00000008", o_valid, o_pc, o_req, o_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h8) begin
      miscompares++; $display("FAIL bp_resume: got valid=%b pc=%08h expected 1 00000008", o_valid, o_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    mem_lat = 3;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    mem_lat = 1;
    vectors++;
    if (o_req !== 1'b1 || o_addr !== 32'h8 || o_valid !== 1'b1 || o_pc !== 32'h4) begin
      miscompares++;
      $display("FAIL rw_setup: got req=%b addr=%08h valid=%b pc=%08h expected 1 00000008 1 00000004", o_req, o_addr, o_valid, o_pc);
    end
    step(1'b0, 1'b1, 32'h100, 1'b0);
    vectors++;
    if (o_req !== 1'b0) begin miscompares++; $display("FAIL rw_redirect_req: got %b expected 0", o_req); end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (o_valid !== 1'b0) begin
        miscompares++; $display("FAIL rw_flushed[%0d]: got valid=%b pc=%08h expected valid 0", j, o_valid, o_pc);
      end
      vectors++;
      if (o_req !== (j == 2)) begin miscompares++; $display("FAIL rw_req[%0d]: got %b expected %b", j, o_req, (j == 2)); end
      if (j == 2) begin
        vectors++;
        if (o_addr !== 32'h100) begin miscompares++; $display("FAIL rw_addr: got %08h expected 00000100", o_addr); end
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL rw_head: got valid=%b pc=%08h instr=%08h expected 1 00000100 %08h", o_valid, o_pc, o_instr, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    vectors++;
    if (o_req !== 1'b0) begin miscompares++; $display("FAIL ra_req_same: got %b expected 0", o_req); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_req !== 1'b1 || o_addr !== 32'h200 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL ra_next: got req=%b addr=%08h valid=%b expected 1 00000200 0", o_req, o_addr, o_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL ra_empty: got valid=%b expected 0", o_valid); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_instr !== mem_word(32'h200)) begin
      miscompares++;
      $display("FAIL ra_head: got valid=%b pc=%08h instr=%08h expected 1 00000200 %08h", o_valid, o_pc, o_instr, mem_word(32'h200));
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    mem_lat = 3;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    mem_pending = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_req !== 1'b0) begin miscompares++; $display("FAIL rsw_req_in_rst: got %b expected 0", o_req); end
    force_ack = 1'b1;
    force_data = 32'hDEAD_BEEF;
    mem_lat = 2;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_req !== 1'b1 || o_addr !== 32'h0 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL rsw_first: got req=%b addr=%08h valid=%b expected 1 00000000 0", o_req, o_addr, o_valid);
    end
    for (int j = 0; j < 2; j++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (o_valid !== 1'b0 || o_req !== 1'b0) begin
        miscompares++; $display("FAIL rsw_wait[%0d]: got valid=%b req=%b expected 0 0", j, o_valid, o_req);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== mem_word(32'h0)) begin
      miscompares++;
      $display("FAIL rsw_head: got valid=%b pc=%08h instr=%08h expected 1 00000000 %08h", o_valid, o_pc, o_instr, mem_word(32'h0));
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_req !== 1'b1 || o_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL pp_setup: got valid=%b pc=%08h req=%b addr=%08h expected 1 00000000 1 00000004", o_valid, o_pc, o_req, o_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== mem_word(32'h4) || o_req !== 1'b1 || o_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL pp_advance: got valid=%b pc=%08h instr=%08h req=%b addr=%08h expected 1 00000004 %08h 1 00000008",
               o_valid, o_pc, o_instr, o_req, o_addr, mem_word(32'h4));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_req !== 1'b0) begin
      miscompares++; $display("FAIL pp_full_hold: got valid=%b pc=%08h req=%b expected 1 00000004 0", o_valid, o_pc, o_req);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h300, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_req !== 1'b0) begin
      miscompares++; $display("FAIL pp_order: got valid=%b pc=%08h req=%b expected 1 00000008 0", o_valid, o_pc, o_req);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h300) begin
      miscompares++;
      $display("FAIL pp_pop_redirect: got valid=%b req=%b addr=%08h expected 0 1 00000300", o_valid, o_req, o_addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_wait();
    test_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
